// File: rtl/ram_pkg.sv
// Shared types for the handshake RAM: FSM state encoding and the wait-state counter.
package ram_pkg;

    localparam int CNTW = 4;

    typedef logic [CNTW-1:0] count_t;

    typedef enum logic [1:0] {
        LEER    = 2'd0,
        WARTEN  = 2'd1,
        ZUGRIFF = 2'd2
    } state_t;

endpackage

// File: rtl/ram_handshake_if.sv
// Request/response bundle between a requester (master) and the handshake RAM (slave).
interface ram_handshake_if #(
    parameter int WORDSIZE = 32,
    parameter int WORDS    = 256
);
    localparam int BYTES = WORDSIZE / 8;
    localparam int ADDRW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic                Anfrage;
    logic                SchreibenAn;
    logic [BYTES-1:0]    ByteAn;
    logic [ADDRW-1:0]    Adresse;
    logic [WORDSIZE-1:0] DatenRein;
    logic                Bereit;
    logic                Fertig;
    logic [WORDSIZE-1:0] DatenRaus;
    logic                Fehler;

    modport master (
        output Anfrage, SchreibenAn, ByteAn, Adresse, DatenRein,
        input  Bereit, Fertig, DatenRaus, Fehler
    );

    modport slave (
        input  Anfrage, SchreibenAn, ByteAn, Adresse, DatenRein,
        output Bereit, Fertig, DatenRaus, Fehler
    );

endinterface

// File: rtl/ram_speicherfeld.sv
// Word storage with per-byte write enables and a registered read port.
// The array itself is never reset; only the read register is.
module ram_speicherfeld #(
    parameter int WORDSIZE = 32,
    parameter int WORDS    = 256,
    parameter int ADDRW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                    Clock,
    input  logic                    ResetN,
    input  logic                    schreiben,
    input  logic                    lesen,
    input  logic                    loeschen,
    input  logic [WORDSIZE/8-1:0]   byteAn,
    input  logic [ADDRW-1:0]        adresse,
    input  logic [WORDSIZE-1:0]     datenRein,
    output logic [WORDSIZE-1:0]     datenRaus
);
    localparam int BYTES = WORDSIZE / 8;

    logic [WORDSIZE-1:0] speicher [WORDS];

    always_ff @(posedge Clock) begin
        if (schreiben) begin
            for (int i = 0; i < BYTES; i++) begin
                if (byteAn[i]) begin
                    speicher[adresse][8*i +: 8] <= datenRein[8*i +: 8];
                end
            end
        end
    end

    // loeschen wins over lesen so an out-of-range read always yields zero
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            datenRaus <= '0;
        end else if (loeschen) begin
            datenRaus <= '0;
        end else if (lesen) begin
            datenRaus <= speicher[adresse];
        end
    end

endmodule

// File: rtl/ram_handshake.sv
// Handshake front end for a word RAM: one request at a time, WAITSTATES idle cycles,
// then a single access cycle; Fertig/Fehler are registered and pulse for one cycle.
module ram_handshake
    import ram_pkg::*;
#(
    parameter int WORDSIZE   = 32,
    parameter int WORDS      = 256,
    parameter int WAITSTATES = 0
) (
    input  logic           Clock,
    input  logic           ResetN,
    ram_handshake_if.slave bus
);
    localparam int              BYTES     = WORDSIZE / 8;
    localparam int              ADDRW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDRW:0]  ADRGRENZE = (ADDRW + 1)'(WORDS);
    localparam count_t          LADEWERT  = (WAITSTATES > 0) ? count_t'(WAITSTATES - 1) : '0;

    state_t              state;
    state_t              stateNext;
    count_t              count;
    count_t              countNext;

    logic                annahme;
    logic                zugriff;
    logic                imBereich;

    logic                schreibenReg;
    logic [BYTES-1:0]    byteAnReg;
    logic [ADDRW-1:0]    adresseReg;
    logic [WORDSIZE-1:0] datenReg;

    logic                fertigReg;
    logic                fehlerReg;
    logic                schreibFreigabe;
    logic                leseFreigabe;
    logic                leseLoeschen;

    assign annahme   = bus.Anfrage && (state == LEER);
    assign zugriff   = (state == ZUGRIFF);
    assign imBereich = ({1'b0, adresseReg} < ADRGRENZE);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state <= LEER;
            count <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    // The counter is preloaded with WAITSTATES-1 so ZUGRIFF follows the cycle it reads 0
    always_comb begin
        stateNext = state;
        countNext = count;
        case (state)
            LEER: begin
                if (bus.Anfrage) begin
                    if (WAITSTATES > 0) begin
                        stateNext = WARTEN;
                        countNext = LADEWERT;
                    end else begin
                        stateNext = ZUGRIFF;
                    end
                end
            end
            WARTEN: begin
                if (count == '0) begin
                    stateNext = ZUGRIFF;
                end else begin
                    countNext = count - 1'b1;
                end
            end
            ZUGRIFF: begin
                stateNext = LEER;
            end
            default: begin
                stateNext = LEER;
                countNext = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            schreibenReg <= 1'b0;
            byteAnReg    <= '0;
            adresseReg   <= '0;
            datenReg     <= '0;
        end else if (annahme) begin
            schreibenReg <= bus.SchreibenAn;
            byteAnReg    <= bus.ByteAn;
            adresseReg   <= bus.Adresse;
            datenReg     <= bus.DatenRein;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            fertigReg <= 1'b0;
            fehlerReg <= 1'b0;
        end else begin
            fertigReg <= zugriff;
            fehlerReg <= zugriff && !imBereich;
        end
    end

    assign schreibFreigabe = zugriff && schreibenReg && imBereich;
    assign leseFreigabe    = zugriff && !schreibenReg && imBereich;
    assign leseLoeschen    = zugriff && !schreibenReg && !imBereich;

    ram_speicherfeld #(
        .WORDSIZE (WORDSIZE),
        .WORDS    (WORDS),
        .ADDRW    (ADDRW)
    ) speicherfeld (
        .Clock     (Clock),
        .ResetN    (ResetN),
        .schreiben (schreibFreigabe),
        .lesen     (leseFreigabe),
        .loeschen  (leseLoeschen),
        .byteAn    (byteAnReg),
        .adresse   (adresseReg),
        .datenRein (datenReg),
        .datenRaus (bus.DatenRaus)
    );

    assign bus.Bereit = (state == LEER);
    assign bus.Fertig = fertigReg;
    assign bus.Fehler = fehlerReg;

endmodule

// File: tb/tb_ram_handshake.sv
// Directed bench for ram_handshake: three instances cover WAITSTATES 0, 3 and 2,
// the first with WORDS=200 so out-of-range addresses can be exercised.
module tb_ram_handshake;

    logic Clock;
    logic rstAB;
    logic rstC;
    int   checks = 0;
    int   errors = 0;

    ram_handshake_if #(.WORDSIZE(32), .WORDS(200)) busA ();
    ram_handshake_if #(.WORDSIZE(32), .WORDS(256)) busB ();
    ram_handshake_if #(.WORDSIZE(32), .WORDS(256)) busC ();

    ram_handshake #(.WORDSIZE(32), .WORDS(200), .WAITSTATES(0)) dutA (
        .Clock (Clock), .ResetN (rstAB), .bus (busA)
    );
    ram_handshake #(.WORDSIZE(32), .WORDS(256), .WAITSTATES(3)) dutB (
        .Clock (Clock), .ResetN (rstAB), .bus (busB)
    );
    ram_handshake #(.WORDSIZE(32), .WORDS(256), .WAITSTATES(2)) dutC (
        .Clock (Clock), .ResetN (rstC), .bus (busC)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [3:0] be, input logic [7:0] adr,
                                 input logic [31:0] din);
        busA.SchreibenAn = wr;
        busA.ByteAn      = be;
        busA.Adresse     = adr;
        busA.DatenRein   = din;
        busA.Anfrage     = 1'b1;
    endtask

    // Inputs are scrambled right after the accept edge; the access must use the latched copy
    task automatic accessA(input string tag, input logic wr, input logic [3:0] be, input logic [7:0] adr,
                           input logic [31:0] din, input logic [31:0] expRaus, input logic expFehler);
        checkOutput({tag, " bereit"}, 32'(busA.Bereit), 32'd1);
        applyStimulus(wr, be, adr, din);
        @(negedge Clock);
        busA.Anfrage     = 1'b0;
        busA.SchreibenAn = ~wr;
        busA.ByteAn      = ~be;
        busA.Adresse     = ~adr;
        busA.DatenRein   = ~din;
        checkOutput({tag, " busy"}, 32'(busA.Bereit), 32'd0);
        checkOutput({tag, " fertig early"}, 32'(busA.Fertig), 32'd0);
        @(negedge Clock);
        checkOutput({tag, " fertig"}, 32'(busA.Fertig), 32'd1);
        checkOutput({tag, " fehler"}, 32'(busA.Fehler), 32'(expFehler));
        checkOutput({tag, " daten"}, busA.DatenRaus, expRaus);
    endtask

    // Drives one request into dutC and returns at the negedge where Fertig is due
    task automatic requestC(input logic wr, input logic [7:0] adr, input logic [31:0] din);
        busC.SchreibenAn = wr;
        busC.ByteAn      = 4'hF;
        busC.Adresse     = adr;
        busC.DatenRein   = din;
        busC.Anfrage     = 1'b1;
        @(negedge Clock);
        busC.Anfrage = 1'b0;
        repeat (3) @(negedge Clock);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        busA.Anfrage = 1'b0; busA.SchreibenAn = 1'b0; busA.ByteAn = '0; busA.Adresse = '0; busA.DatenRein = '0;
        busB.Anfrage = 1'b0; busB.SchreibenAn = 1'b0; busB.ByteAn = '0; busB.Adresse = '0; busB.DatenRein = '0;
        busC.Anfrage = 1'b0; busC.SchreibenAn = 1'b0; busC.ByteAn = '0; busC.Adresse = '0; busC.DatenRein = '0;
        rstAB = 1'b1;
        rstC  = 1'b1;
        #2;
        rstAB = 1'b0;
        rstC  = 1'b0;
        @(negedge Clock);
        checkOutput("reset bereit",    32'(busA.Bereit), 32'd1);
        checkOutput("reset fertig",    32'(busA.Fertig), 32'd0);
        checkOutput("reset fehler",    32'(busA.Fehler), 32'd0);
        checkOutput("reset datenraus", busA.DatenRaus,   32'd0);
        checkOutput("reset bereit B",  32'(busB.Bereit), 32'd1);
        rstAB = 1'b1;
        rstC  = 1'b1;
        @(negedge Clock);

        // WAITSTATES=0, WORDS=200
        accessA("wr5",        1'b1, 4'hF, 8'd5,   32'hDEADBEEF, 32'h00000000, 1'b0);
        accessA("rd5",        1'b0, 4'h0, 8'd5,   32'h00000000, 32'hDEADBEEF, 1'b0);
        accessA("wr7 full",   1'b1, 4'hF, 8'd7,   32'h11223344, 32'hDEADBEEF, 1'b0);
        accessA("wr7 bytes",  1'b1, 4'h5, 8'd7,   32'hAABBCCDD, 32'hDEADBEEF, 1'b0);
        accessA("rd7",        1'b0, 4'h0, 8'd7,   32'h00000000, 32'h11BB33DD, 1'b0);
        accessA("wr10",       1'b1, 4'hF, 8'd10,  32'hCAFEF00D, 32'h11BB33DD, 1'b0);
        accessA("wr210",      1'b1, 4'hF, 8'd210, 32'h12345678, 32'h11BB33DD, 1'b1);
        accessA("rd210",      1'b0, 4'hF, 8'd210, 32'h00000000, 32'h00000000, 1'b1);
        accessA("rd200",      1'b0, 4'h0, 8'd200, 32'h00000000, 32'h00000000, 1'b1);
        accessA("rd10",       1'b0, 4'h0, 8'd10,  32'h00000000, 32'hCAFEF00D, 1'b0);
        accessA("wr5 none",   1'b1, 4'h0, 8'd5,   32'h00000000, 32'hCAFEF00D, 1'b0);
        accessA("wr5 top",    1'b1, 4'h8, 8'd5,   32'h77000000, 32'hCAFEF00D, 1'b0);
        accessA("rd5 merged", 1'b0, 4'h0, 8'd5,   32'h00000000, 32'h77ADBEEF, 1'b0);
        @(negedge Clock);
        checkOutput("A fertig pulse end", 32'(busA.Fertig), 32'd0);

        // WAITSTATES=3: a competing request during the wait must vanish
        busB.SchreibenAn = 1'b1;
        busB.ByteAn      = 4'hF;
        busB.Adresse     = 8'd3;
        busB.DatenRein   = 32'h0BADCAFE;
        busB.Anfrage     = 1'b1;
        checkOutput("B wr bereit", 32'(busB.Bereit), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clock);
            checkOutput($sformatf("B wr bereit wait%0d", k), 32'(busB.Bereit), 32'd0);
            checkOutput($sformatf("B wr fertig wait%0d", k), 32'(busB.Fertig), 32'd0);
            busB.DatenRein = 32'h55555555;
            busB.Anfrage   = (k < 4);
        end
        @(negedge Clock);
        checkOutput("B wr fertig", 32'(busB.Fertig), 32'd1);
        checkOutput("B wr bereit after", 32'(busB.Bereit), 32'd1);
        @(negedge Clock);
        checkOutput("B no queued access", 32'(busB.Bereit), 32'd1);
        checkOutput("B fertig low", 32'(busB.Fertig), 32'd0);
        busB.SchreibenAn = 1'b0;
        busB.Adresse     = 8'd3;
        busB.Anfrage     = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clock);
            busB.Anfrage = 1'b0;
            checkOutput($sformatf("B rd fertig wait%0d", k), 32'(busB.Fertig), 32'd0);
        end
        @(negedge Clock);
        checkOutput("B rd fertig", 32'(busB.Fertig), 32'd1);
        checkOutput("B rd daten", busB.DatenRaus, 32'h0BADCAFE);

        // WAITSTATES=2: reset during WARTEN aborts the write
        requestC(1'b1, 8'd9, 32'h13572468);
        checkOutput("C preload fertig", 32'(busC.Fertig), 32'd1);
        requestC(1'b0, 8'd9, 32'h00000000);
        checkOutput("C rd fertig", 32'(busC.Fertig), 32'd1);
        checkOutput("C rd daten", busC.DatenRaus, 32'h13572468);
        busC.SchreibenAn = 1'b1;
        busC.ByteAn      = 4'hF;
        busC.Adresse     = 8'd9;
        busC.DatenRein   = 32'hFFFFFFFF;
        busC.Anfrage     = 1'b1;
        @(negedge Clock);
        busC.Anfrage = 1'b0;
        checkOutput("C in wait", 32'(busC.Bereit), 32'd0);
        rstC = 1'b0;
        #1;
        checkOutput("C reset bereit", 32'(busC.Bereit), 32'd1);
        checkOutput("C reset fertig", 32'(busC.Fertig), 32'd0);
        checkOutput("C reset daten", busC.DatenRaus, 32'd0);
        @(negedge Clock);
        rstC = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge Clock);
            checkOutput($sformatf("C aborted fertig%0d", k), 32'(busC.Fertig), 32'd0);
        end
        requestC(1'b0, 8'd9, 32'h00000000);
        checkOutput("C rd after abort fertig", 32'(busC.Fertig), 32'd1);
        checkOutput("C rd after abort daten", busC.DatenRaus, 32'h13572468);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_handshake.md
RAM_HANDSHAKE -- requirements
Module: ram_handshake

Interface
REQ-001 SHALL have parameter WORDSIZE, default 32, data word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter WORDS, default 256, number of storage words; need not be a power of two.
REQ-003 SHALL have parameter WAITSTATES, default 0, extra cycles inserted before each access; range 0..15.
REQ-004 SHALL have port Clock  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port ResetN  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Anfrage  input  1  request valid.
REQ-007 SHALL have port SchreibenAn  input  1  1 = write request, 0 = read request; sampled with Anfrage.
REQ-008 SHALL have port ByteAn  input  WORDSIZE/8  byte enables for writes; bit i selects bits 8i+7..8i.
REQ-009 SHALL have port Adresse  input  $clog2(WORDS)  word address.
REQ-010 SHALL have port DatenRein  input  WORDSIZE  write data.
REQ-011 SHALL have port Bereit  output  1  block can accept a request this cycle.
REQ-012 SHALL have port Fertig  output  1  one-cycle pulse: current access complete.
REQ-013 SHALL have port DatenRaus  output  WORDSIZE  read data; valid while Fertig is high for a read, held otherwise.
REQ-014 SHALL have port Fehler  output  1  one-cycle pulse together with Fertig: address was out of range.

Function
REQ-015 SHALL be a three-state FSM: LEER (idle), WARTEN (wait states), ZUGRIFF (access).
REQ-016 SHALL drive Bereit = 1 exactly when the state is LEER; the value is combinational from state only.
REQ-017 SHALL accept a request when Anfrage=1 and Bereit=1, latching SchreibenAn, ByteAn, Adresse and DatenRein in that cycle; later input changes SHALL NOT affect the access.
REQ-018 On accept, SHALL go to WARTEN with the counter loaded to WAITSTATES-1 when WAITSTATES>0, and directly to ZUGRIFF when WAITSTATES=0.
REQ-019 In WARTEN, SHALL decrement the counter each cycle and go to ZUGRIFF in the cycle after the counter reads 0.
REQ-020 In ZUGRIFF, SHALL perform the array access, assert Fertig for exactly that cycle, and return to LEER.
REQ-021 Latency from the accept edge to Fertig high SHALL be WAITSTATES+1 cycles; back-to-back throughput SHALL be one access per WAITSTATES+2 cycles.
REQ-022 A write SHALL update only the bytes whose ByteAn bit is 1; ByteAn=0 SHALL leave memory unchanged and still produce Fertig.
REQ-023 A read SHALL ignore ByteAn and update DatenRaus with the full word in the ZUGRIFF cycle, registered so it is visible while Fertig=1.
REQ-024 DatenRaus SHALL hold its last value when no read completes, including across writes.
REQ-025 If the latched Adresse >= WORDS: writes SHALL be discarded, reads SHALL set DatenRaus to 0, and Fehler SHALL pulse with Fertig.
REQ-026 Anfrage while Bereit=0 SHALL be ignored; requests are neither queued nor merged.

Reset
REQ-027 ResetN low SHALL force, asynchronously, state LEER, counter 0, Fertig 0, Fehler 0 and DatenRaus 0; Bereit becomes 1.
REQ-028 Reset asserted mid-operation SHALL abort the access: no memory write and no Fertig pulse.
REQ-029 Memory contents SHALL NOT be reset or initialised and are undefined after power-up.

Structure
REQ-030 A shared package ram_pkg SHALL hold the FSM state type (LEER, WARTEN, ZUGRIFF) and the counter width constant (4 bits).
REQ-031 The storage array with byte-enable write and registered read SHALL be a sub-module ram_speicherfeld; the FSM, latches and range check stay in ram_handshake.

Verification
REQ-032 With WAITSTATES=0: write 0xDEADBEEF to address 5 with ByteAn=1111, then read address 5 -> Fertig 1 cycle after each accept; DatenRaus=0xDEADBEEF; Fehler=0.
REQ-033 With WAITSTATES=3: read request -> Bereit low for 4 cycles, Fertig at cycle 4 after accept; a second Anfrage during the wait is ignored.
REQ-034 Address 7 preloaded with 0x11223344; write 0xAABBCCDD with ByteAn=0101; read address 7 -> DatenRaus=0x11BB33DD.
REQ-035 With WORDS=200: write to address 210, then read address 210 -> both return Fertig+Fehler; the read returns DatenRaus=0; address 200 is still unwritten.
REQ-036 With WAITSTATES=2: write request, assert ResetN low in the WARTEN state -> no Fertig; the target word is unchanged on a later read; Bereit=1 immediately.
REQ-037 Change Adresse and DatenRein on the cycle after accept -> the access uses the latched values.
